// File: rtl/pattern_generator_pkg.sv
// Shared types and constants for the pattern generator: FSM encoding,
// LFSR feedback taps, pattern width and the pattern fix-up helper.
package pattern_gen_pkg;

  localparam int unsigned PATTERN_W = 8;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GAP  = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Turn a raw LFSR byte into a lamp pattern that is never zero and never
  // repeats the previous pattern.
  function automatic logic [PATTERN_W-1:0] fix_pattern(
    input logic [PATTERN_W-1:0] cand,
    input logic [PATTERN_W-1:0] last
  );
    logic [PATTERN_W-1:0] c1;
    logic [PATTERN_W-1:0] c2;
    c1 = (cand == 8'h00) ? 8'h01 : cand;
    if (c1 != last) begin
      c2 = c1;
    end else if (c1 == 8'hFF) begin
      c2 = 8'h7F;
    end else begin
      c2 = ~c1;
    end
    return c2;
  endfunction

endpackage

// File: rtl/pattern_generator_if.sv
// Game-control bus between the pattern generator and its controller /
// score_calculator side.
interface pattern_generator_if;
  import pattern_gen_pkg::*;

  logic                 start;
  logic                 stop;
  logic [PATTERN_W-1:0] pending_pattern;
  logic [PATTERN_W-1:0] pattern;
  logic                 busy;
  logic                 done;
  logic [7:0]           round_count;
  logic [7:0]           miss_count;

  modport master (
    output start, stop, pending_pattern,
    input  pattern, busy, done, round_count, miss_count
  );

  modport slave (
    input  start, stop, pending_pattern,
    output pattern, busy, done, round_count, miss_count
  );

endinterface

// File: rtl/pattern_generator_lfsr16.sv
// Free-running 16-bit Galois LFSR; reloads the seed on reset and steps on
// every clock otherwise.
module lfsr16
  import pattern_gen_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] lfsr_r;

  // Galois step: shift right, fold the taps in when the outgoing bit is 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_r <= seed;
    end else if (lfsr_r[0]) begin
      lfsr_r <= (lfsr_r >> 1) ^ LFSR_TAPS;
    end else begin
      lfsr_r <= lfsr_r >> 1;
    end
  end

  assign q = lfsr_r;

endmodule

// File: rtl/pattern_generator.sv
// Game pacer: waits interval ticks, emits a one-cycle non-zero lamp pattern,
// shortens the interval after each cleared pattern, counts misses and ends
// the game after ROUNDS patterns.
module pattern_generator
  import pattern_gen_pkg::*;
#(
  parameter int unsigned TICK_DIV      = 100000,
  parameter int unsigned INIT_INTERVAL = 1000,
  parameter int unsigned MIN_INTERVAL  = 200,
  parameter int unsigned STEP          = 50,
  parameter int unsigned ROUNDS        = 32,
  parameter logic [15:0] SEED          = 16'hACE1
)(
  input  logic              clock100m,
  input  logic              reset_n,
  pattern_generator_if.slave bus
);

  localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [15:0] INIT_IV = 16'(INIT_INTERVAL);
  localparam logic [16:0] MIN_IV  = 17'(MIN_INTERVAL);
  localparam logic [16:0] STEP_IV = 17'(STEP);
  localparam logic [7:0]  ROUNDS_C = 8'(ROUNDS);

  state_e               state_r;
  state_e               next_state_s;
  logic [DIV_W-1:0]     div_cnt_r;
  logic [15:0]          tick_cnt_r;
  logic [15:0]          interval_r;
  logic [PATTERN_W-1:0] last_r;
  logic [7:0]           round_r;
  logic [7:0]           miss_r;
  logic                 busy_r;
  logic                 done_r;
  logic [15:0]          lfsr_q_s;
  logic [PATTERN_W-1:0] pat_s;
  logic                 tick_wrap_s;
  logic                 gap_end_s;
  logic [16:0]          iv_diff_s;
  logic [15:0]          iv_next_s;

  lfsr16 u_lfsr (
    .clk     (clock100m),
    .reset_n (reset_n),
    .seed    (SEED),
    .q       (lfsr_q_s)
  );

  assign pat_s       = fix_pattern(lfsr_q_s[PATTERN_W-1:0], last_r);
  assign tick_wrap_s = (div_cnt_r == DIV_LAST);
  assign gap_end_s   = tick_wrap_s && (tick_cnt_r == (interval_r - 16'd1));

  // Speed-up: subtract one step with a borrow bit, then clamp to the floor.
  always_comb begin
    iv_diff_s = {1'b0, interval_r} - STEP_IV;
    if (iv_diff_s[16] || (iv_diff_s < MIN_IV)) begin
      iv_next_s = MIN_IV[15:0];
    end else begin
      iv_next_s = iv_diff_s[15:0];
    end
  end

  // Next-state decode; stop beats every other transition.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.stop) begin
          next_state_s = ST_IDLE;
        end else if (bus.start) begin
          next_state_s = ST_GAP;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (bus.stop) begin
          next_state_s = ST_IDLE;
        end else if (gap_end_s) begin
          next_state_s = (round_r >= ROUNDS_C) ? ST_DONE : ST_EMIT;
        end else begin
          next_state_s = ST_GAP;
        end
      end
      ST_EMIT: begin
        if (bus.stop) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_GAP;
        end
      end
      ST_DONE: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State register plus busy/done, registered from the upcoming state.
  always_ff @(posedge clock100m or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s == ST_GAP) || (next_state_s == ST_EMIT);
      done_r  <= (next_state_s == ST_DONE);
    end
  end

  // Game datapath: tick divider, gap counter, pacing and round/miss counts.
  always_ff @(posedge clock100m or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_r  <= '0;
      tick_cnt_r <= 16'd0;
      interval_r <= INIT_IV;
      last_r     <= 8'h00;
      round_r    <= 8'd0;
      miss_r     <= 8'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start && !bus.stop) begin
            div_cnt_r  <= '0;
            tick_cnt_r <= 16'd0;
            interval_r <= INIT_IV;
            last_r     <= 8'h00;
            round_r    <= 8'd0;
            miss_r     <= 8'd0;
          end
        end
        ST_GAP: begin
          if (!bus.stop) begin
            if (tick_wrap_s) begin
              div_cnt_r  <= '0;
              tick_cnt_r <= gap_end_s ? 16'd0 : (tick_cnt_r + 16'd1);
            end else begin
              div_cnt_r <= div_cnt_r + DIV_W'(1);
            end
          end
        end
        ST_EMIT: begin
          if (!bus.stop) begin
            last_r     <= pat_s;
            round_r    <= round_r + 8'd1;
            div_cnt_r  <= '0;
            tick_cnt_r <= 16'd0;
            // Nothing is outstanding before the first emit, so a zero
            // pending_pattern counts as cleared there too; a miss needs a
            // previously emitted pattern.
            if (bus.pending_pattern == 8'h00) begin
              interval_r <= iv_next_s;
            end else if ((round_r != 8'd0) && (miss_r != 8'hFF)) begin
              miss_r <= miss_r + 8'd1;
            end
          end
        end
        ST_DONE: begin
          round_r <= round_r;
        end
        default: begin
          round_r <= round_r;
        end
      endcase
    end
  end

  // The pulse is gated by stop in the same cycle, so it cannot be registered.
  assign bus.pattern     = ((state_r == ST_EMIT) && !bus.stop) ? pat_s : 8'h00;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.round_count = round_r;
  assign bus.miss_count  = miss_r;

endmodule

// File: tb/tb_pattern_generator.sv
// Directed bench for pattern_generator with a shortened tick (TICK_DIV=4).
module tb_pattern_generator;
  import pattern_gen_pkg::*;

  logic clock100m = 1'b0;
  logic reset_n   = 1'b0;
  int   checks    = 0;
  int   errors    = 0;
  logic [15:0] m_lfsr;
  logic [7:0]  m_last;

  pattern_generator_if bus ();

  pattern_generator #(
    .TICK_DIV      (4),
    .INIT_INTERVAL (5),
    .MIN_INTERVAL  (2),
    .STEP          (2),
    .ROUNDS        (3),
    .SEED          (16'hACE1)
  ) dut (
    .clock100m (clock100m),
    .reset_n   (reset_n),
    .bus       (bus)
  );

  always #5 clock100m = ~clock100m;

  // Reference LFSR stepping alongside the design's generator.
  always @(posedge clock100m or negedge reset_n) begin
    if (!reset_n) m_lfsr <= 16'hACE1;
    else if (m_lfsr[0]) m_lfsr <= (m_lfsr >> 1) ^ 16'hB400;
    else m_lfsr <= m_lfsr >> 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_pat(input logic [7:0] cand, input logic [7:0] prev);
    logic [7:0] c;
    c = (cand == 8'h00) ? 8'h01 : cand;
    if (c != prev) return c;
    else if (c == 8'hFF) return 8'h7F;
    else return ~c;
  endfunction

  task automatic do_start();
    @(negedge clock100m);
    bus.start = 1'b1;
    @(posedge clock100m);
    #1 bus.start = 1'b0;
    m_last = 8'h00;
  endtask

  // One full game from start; cycle n is the n-th falling edge after the
  // start edge.  restart_at pulses start while busy (0 = never).
  task automatic run_game(input logic [7:0] pend, input int p0, input int p1, input int p2,
                          input int done_at, input int exp_miss, input int restart_at);
    int pt[3];
    int np;
    int dt;
    int nd;
    logic [7:0] ep;
    np = 0; dt = 0; nd = 0;
    bus.pending_pattern = pend;
    do_start();
    for (int n = 1; n <= done_at + 1; n++) begin
      @(negedge clock100m);
      bus.start = (n == restart_at);
      if (n == 1) check_eq("busy_after_start", {31'd0, bus.busy}, 32'd1);
      if (bus.pattern != 8'h00) begin
        ep = exp_pat(m_lfsr[7:0], m_last);
        check_eq("pattern_value", {24'd0, bus.pattern}, {24'd0, ep});
        m_last = ep;
        if (np < 3) pt[np] = n;
        np++;
      end
      if (bus.done) begin
        if (nd == 0) dt = n;
        nd++;
      end
    end
    bus.start = 1'b0;
    check_eq("pulse_count", np, 3);
    check_eq("pulse0_cycle", (np > 0) ? pt[0] : 0, p0);
    check_eq("pulse1_cycle", (np > 1) ? pt[1] : 0, p1);
    check_eq("pulse2_cycle", (np > 2) ? pt[2] : 0, p2);
    check_eq("done_count", nd, 1);
    check_eq("done_cycle", dt, done_at);
    check_eq("round_count", {24'd0, bus.round_count}, 32'd3);
    check_eq("miss_count", {24'd0, bus.miss_count}, exp_miss);
    check_eq("busy_after_done", {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    int nz;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.pending_pattern = 8'h00;
    m_last = 8'h00;

    // 1: reset state and idle without start
    repeat (3) @(negedge clock100m);
    check_eq("rst_pattern", {24'd0, bus.pattern}, 32'd0);
    check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("rst_done", {31'd0, bus.done}, 32'd0);
    check_eq("rst_round", {24'd0, bus.round_count}, 32'd0);
    check_eq("rst_miss", {24'd0, bus.miss_count}, 32'd0);
    reset_n = 1'b1;
    nz = 0;
    repeat (100) begin
      @(negedge clock100m);
      if (bus.pattern != 8'h00 || bus.busy || bus.done) nz++;
    end
    check_eq("idle_quiet", nz, 0);

    // 4: fix-up vectors, including zero candidate and repeats
    check_eq("fix_ff_ff", {24'd0, fix_pattern(8'hFF, 8'hFF)}, 32'h7F);
    check_eq("fix_00_01", {24'd0, fix_pattern(8'h00, 8'h01)}, 32'hFE);
    check_eq("fix_00_00", {24'd0, fix_pattern(8'h00, 8'h00)}, 32'h01);
    check_eq("fix_5a_5a", {24'd0, fix_pattern(8'h5A, 8'h5A)}, 32'hA5);
    check_eq("fix_5a_00", {24'd0, fix_pattern(8'h5A, 8'h00)}, 32'h5A);

    // 2: all cleared -> intervals 5,3,2, final gap 2
    run_game(8'h00, 21, 34, 43, 52, 0, 0);

    // 3: never cleared -> period stays 21, two misses
    run_game(8'h3C, 21, 42, 63, 84, 2, 0);

    // 5: stop in the first EMIT cycle
    bus.pending_pattern = 8'h00;
    do_start();
    repeat (21) @(negedge clock100m);
    check_eq("emit_before_stop", {31'd0, (bus.pattern != 8'h00)}, 32'd1);
    bus.stop = 1'b1;
    #1;
    check_eq("stop_pattern", {24'd0, bus.pattern}, 32'd0);
    @(negedge clock100m);
    bus.stop = 1'b0;
    check_eq("stop_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("stop_round_hold", {24'd0, bus.round_count}, 32'd0);
    run_game(8'h00, 21, 34, 43, 52, 0, 0);

    // 6: reset mid-GAP after one pattern, then start while busy
    do_start();
    repeat (30) @(negedge clock100m);
    check_eq("pre_reset_round", {24'd0, bus.round_count}, 32'd1);
    reset_n = 1'b0;
    #1;
    check_eq("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("midrst_round", {24'd0, bus.round_count}, 32'd0);
    check_eq("midrst_pattern", {24'd0, bus.pattern}, 32'd0);
    repeat (2) @(negedge clock100m);
    reset_n = 1'b1;
    nz = 0;
    repeat (25) begin
      @(negedge clock100m);
      if (bus.pattern != 8'h00 || bus.busy) nz++;
    end
    check_eq("post_reset_idle", nz, 0);
    run_game(8'h00, 21, 34, 43, 52, 0, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
